// File: rtl/rast_params.sv
// Shared rasterizer parameters and the scheduler's data and state types.
package rast_params;
   localparam int SIGFIG = 24;
   localparam int VERTS  = 3;
   localparam int AXIS   = 3;
   localparam int COLORS = 3;

   typedef logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
   typedef logic [COLORS-1:0][SIGFIG-1:0]                 color_t;
   typedef logic signed [1:0][SIGFIG-1:0]                 screen_t;

   typedef enum logic [2:0] {UNCFG, RUN, FLUSH, DRAIN, APPLY} sched_state_e;
endpackage

// File: rtl/rast_tri_fifo.sv
// Synchronous FIFO holding packed {triangle, color} entries for the issue port.
module rast_tri_fifo
   import rast_params::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             din,
   input  logic                     pop,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A full FIFO may still accept a push when the head leaves the same cycle.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/rast_tri_sched.sv
// Triangle issue scheduler: buffers upstream triangles and swaps rast config
// only once the rasterizer pipeline is provably empty.
module rast_tri_sched
   import rast_params::*;
#(
   parameter int SIGFIG       = rast_params::SIGFIG,
   parameter int VERTS        = rast_params::VERTS,
   parameter int AXIS         = rast_params::AXIS,
   parameter int COLORS       = rast_params::COLORS,
   parameter int FIFO_DEPTH   = 4,
   parameter int DRAIN_CYCLES = 16
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] in_tri_S,
   input  logic [COLORS-1:0][SIGFIG-1:0]                in_color_U,
   input  logic                                         in_valid,
   output logic                                         in_ready,
   input  logic signed [1:0][SIGFIG-1:0]                cfg_screen_S,
   input  logic [3:0]                                   cfg_subSample_U,
   input  logic                                         cfg_valid,
   output logic                                         cfg_ready,
   output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R10S,
   output logic [COLORS-1:0][SIGFIG-1:0]                color_R10U,
   output logic                                         validTri_R10H,
   input  logic                                         halt_RnnnnL,
   output logic signed [1:0][SIGFIG-1:0]                screen_RnnnnS,
   output logic [3:0]                                   subSample_RnnnnU,
   output logic                                         busy,
   output logic [15:0]                                  tri_count
);
   localparam int ENT_W  = VERTS*AXIS*SIGFIG + COLORS*SIGFIG;
   localparam int DCNT_W = $clog2(DRAIN_CYCLES+1);

   sched_state_e                  state;
   logic [DCNT_W-1:0]             drain_cnt;
   logic                          push, pop, full, empty;
   logic [$clog2(FIFO_DEPTH):0]   fifo_count;
   logic [ENT_W-1:0]              head;

   // Config requests take priority over triangles arriving the same cycle.
   assign in_ready      = (state == RUN) && !full && !cfg_valid;
   assign validTri_R10H = !empty && (state == RUN || state == FLUSH);
   assign push          = in_valid && in_ready;
   assign pop           = validTri_R10H && halt_RnnnnL;
   assign cfg_ready     = (state == APPLY);
   assign busy          = !empty || (state inside {FLUSH, DRAIN, APPLY});
   assign {tri_R10S, color_R10U} = head;

   rast_tri_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (ENT_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   ({in_tri_S, in_color_U}),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= UNCFG;
         drain_cnt        <= '0;
         screen_RnnnnS    <= '0;
         subSample_RnnnnU <= '0;
         tri_count        <= '0;
      end else begin
         if (pop) tri_count <= tri_count + 16'd1;
         case (state)
            UNCFG: if (cfg_valid) state <= APPLY;
            RUN:   if (cfg_valid) state <= FLUSH;
            FLUSH: if (fifo_count == '0) begin
               state     <= DRAIN;
               drain_cnt <= '0;
            end
            // Rast is empty only after an unbroken run of unhalted idle cycles.
            DRAIN: begin
               if (!halt_RnnnnL)
                  drain_cnt <= '0;
               else if (drain_cnt == DCNT_W'(DRAIN_CYCLES-1))
                  state <= APPLY;
               else
                  drain_cnt <= drain_cnt + DCNT_W'(1);
            end
            APPLY: begin
               screen_RnnnnS    <= cfg_screen_S;
               subSample_RnnnnU <= cfg_subSample_U;
               state            <= RUN;
            end
            default: state <= UNCFG;
         endcase
      end
   end
endmodule

// File: tb/tb_rast_tri_sched.sv
// Directed bench for rast_tri_sched: config bring-up, streaming, backpressure,
// drain timing, drain restart and mid-operation reset.
module tb_rast_tri_sched;
   import rast_params::*;

   logic    clk = 0;
   logic    rst;
   tri_t    in_tri_S;
   color_t  in_color_U;
   logic    in_valid, in_ready;
   screen_t cfg_screen_S;
   logic [3:0] cfg_subSample_U;
   logic    cfg_valid, cfg_ready;
   tri_t    tri_R10S;
   color_t  color_R10U;
   logic    validTri_R10H, halt_RnnnnL;
   screen_t screen_RnnnnS;
   logic [3:0] subSample_RnnnnU;
   logic    busy;
   logic [15:0] tri_count;

   int checks = 0;
   int errors = 0;
   logic early;

   always #5 clk = ~clk;

   rast_tri_sched dut (
      .clk(clk), .rst(rst),
      .in_tri_S(in_tri_S), .in_color_U(in_color_U),
      .in_valid(in_valid), .in_ready(in_ready),
      .cfg_screen_S(cfg_screen_S), .cfg_subSample_U(cfg_subSample_U),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .tri_R10S(tri_R10S), .color_R10U(color_R10U),
      .validTri_R10H(validTri_R10H), .halt_RnnnnL(halt_RnnnnL),
      .screen_RnnnnS(screen_RnnnnS), .subSample_RnnnnU(subSample_RnnnnU),
      .busy(busy), .tri_count(tri_count)
   );

   function automatic tri_t mk_tri(input int id);
      tri_t t;
      for (int v = 0; v < VERTS; v++)
         for (int a = 0; a < AXIS; a++)
            t[v][a] = SIGFIG'((((v + a) % 2) != 0 ? -1 : 1) * (id*16 + v*4 + a));
      return t;
   endfunction

   function automatic color_t mk_col(input int id);
      color_t c;
      for (int k = 0; k < COLORS; k++) c[k] = SIGFIG'(id*8 + k);
      return c;
   endfunction

   function automatic screen_t mk_scr(input int w, input int h);
      screen_t s;
      s[1] = SIGFIG'(w);
      s[0] = SIGFIG'(h);
      return s;
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_tri(input int id);
      in_tri_S   = mk_tri(id);
      in_color_U = mk_col(id);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1; in_valid = 1; set_tri(1);
      cfg_valid = 0; cfg_screen_S = '0; cfg_subSample_U = '0; halt_RnnnnL = 1;
      tick; tick;
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_cfg_ready", cfg_ready, 0);
      chk("rst_valid", validTri_R10H, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tri_count", tri_count, 0);
      chk("rst_screen", screen_RnnnnS, 0);
      chk("rst_subsample", subSample_RnnnnU, 0);
      chk("rst_tri", tri_R10S, 0);
      chk("rst_color", color_R10U, 0);
      rst = 0;

      // Unconfigured: triangles are refused.
      repeat (3) begin
         tick; #1;
         chk("uncfg_in_ready", in_ready, 0);
      end
      in_valid = 0;

      cfg_valid = 1; cfg_screen_S = mk_scr(640, 480); cfg_subSample_U = 4'b0100;
      #1 chk("uncfg_no_cfg_ready", cfg_ready, 0);
      tick; #1;
      chk("uncfg_cfg_ready", cfg_ready, 1);
      chk("apply_screen_old", screen_RnnnnS, 0);
      cfg_valid = 0;
      tick; #1;
      chk("cfg1_screen", screen_RnnnnS, mk_scr(640, 480));
      chk("cfg1_subsample", subSample_RnnnnU, 4'b0100);
      chk("cfg1_ready_low", cfg_ready, 0);
      chk("run_in_ready", in_ready, 1);

      // Back-to-back stream of 10 triangles.
      in_valid = 1;
      for (int i = 1; i <= 10; i++) begin
         set_tri(i);
         #1 chk("stream_in_ready", in_ready, 1);
         if (i == 1) chk("stream_first_valid", validTri_R10H, 0);
         else begin
            chk("stream_valid", validTri_R10H, 1);
            chk("stream_tri", tri_R10S, mk_tri(i-1));
            chk("stream_color", color_R10U, mk_col(i-1));
         end
         tick;
      end
      in_valid = 0;
      #1;
      chk("stream_last_valid", validTri_R10H, 1);
      chk("stream_last_tri", tri_R10S, mk_tri(10));
      tick; #1;
      chk("stream_done_valid", validTri_R10H, 0);
      chk("stream_count", tri_count, 10);
      chk("stream_idle_busy", busy, 0);

      // Backpressure: 5 halted cycles fill the 4-entry FIFO.
      halt_RnnnnL = 0; in_valid = 1;
      for (int k = 0; k < 4; k++) begin
         set_tri(11 + k);
         #1 chk("halt_in_ready", in_ready, 1);
         if (k > 0) begin
            chk("halt_valid", validTri_R10H, 1);
            chk("halt_tri_stable", tri_R10S, mk_tri(11));
         end
         tick;
      end
      set_tri(15);
      #1;
      chk("full_in_ready", in_ready, 0);
      chk("full_tri_stable", tri_R10S, mk_tri(11));
      tick;
      halt_RnnnnL = 1;
      #1;
      chk("full_pop_in_ready", in_ready, 0);
      chk("full_pop_tri", tri_R10S, mk_tri(11));
      chk("full_pop_valid", validTri_R10H, 1);
      tick; #1;
      chk("refill_in_ready", in_ready, 1);
      chk("drain_tri12", tri_R10S, mk_tri(12));
      tick;
      in_valid = 0;
      #1 chk("drain_tri13", tri_R10S, mk_tri(13));
      tick; #1;
      chk("drain_tri14", tri_R10S, mk_tri(14));
      chk("drain_busy", busy, 1);
      tick; #1;
      chk("drain_tri15", tri_R10S, mk_tri(15));
      chk("drain_col15", color_R10U, mk_col(15));
      tick; #1;
      chk("halt_done_valid", validTri_R10H, 0);
      chk("halt_count", tri_count, 15);

      // Config and triangle in the same RUN cycle: config wins.
      cfg_valid = 1; cfg_screen_S = mk_scr(320, 240); cfg_subSample_U = 4'd2;
      in_valid = 1; set_tri(99);
      #1 chk("cfg_prio_in_ready", in_ready, 0);
      tick;
      in_valid = 0;
      #1;
      chk("flush_busy", busy, 1);
      chk("flush_valid", validTri_R10H, 0);
      early = cfg_ready;
      for (int c = 2; c <= 17; c++) begin
         tick; #1;
         early = early | cfg_ready;
      end
      chk("reconf_no_early_ready", early, 0);
      tick; #1;
      chk("reconf_ready_c18", cfg_ready, 1);
      chk("reconf_screen_old", screen_RnnnnS, mk_scr(640, 480));
      cfg_valid = 0;
      tick; #1;
      chk("reconf_screen", screen_RnnnnS, mk_scr(320, 240));
      chk("reconf_subsample", subSample_RnnnnU, 4'd2);
      chk("reconf_ready_low", cfg_ready, 0);
      chk("reconf_tri_rejected", validTri_R10H, 0);
      chk("reconf_count", tri_count, 15);
      chk("reconf_busy", busy, 0);

      // Halt blip at drain count 10 restarts the drain window.
      cfg_valid = 1; cfg_screen_S = mk_scr(1024, 768); cfg_subSample_U = 4'd8;
      tick;
      tick;
      early = 0;
      for (int c = 3; c <= 12; c++) begin
         tick; #1;
         early = early | cfg_ready;
      end
      halt_RnnnnL = 0;
      tick;
      halt_RnnnnL = 1;
      #1 early = early | cfg_ready;
      for (int c = 14; c <= 28; c++) begin
         tick; #1;
         early = early | cfg_ready;
      end
      chk("blip_no_early_ready", early, 0);
      tick; #1;
      chk("blip_ready_c29", cfg_ready, 1);
      cfg_valid = 0;
      tick; #1;
      chk("blip_screen", screen_RnnnnS, mk_scr(1024, 768));
      chk("blip_subsample", subSample_RnnnnU, 4'd8);

      // Reset with 3 triangles queued and a config pending.
      halt_RnnnnL = 0; in_valid = 1;
      for (int k = 0; k < 3; k++) begin
         set_tri(21 + k);
         #1 chk("q_in_ready", in_ready, 1);
         tick;
      end
      in_valid = 0;
      cfg_valid = 1; cfg_screen_S = mk_scr(100, 50); cfg_subSample_U = 4'd1;
      #1;
      chk("q_valid", validTri_R10H, 1);
      chk("q_head", tri_R10S, mk_tri(21));
      tick; #1;
      chk("q_flush_valid", validTri_R10H, 1);
      chk("q_flush_in_ready", in_ready, 0);
      rst = 1;
      tick; #1;
      chk("mid_rst_valid", validTri_R10H, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_count", tri_count, 0);
      chk("mid_rst_cfg_ready", cfg_ready, 0);
      chk("mid_rst_screen", screen_RnnnnS, 0);
      chk("mid_rst_tri", tri_R10S, 0);
      rst = 0; cfg_valid = 0; in_valid = 1; halt_RnnnnL = 1;
      tick; #1;
      chk("post_rst_uncfg_in_ready", in_ready, 0);
      chk("post_rst_valid", validTri_R10H, 0);
      chk("post_rst_busy", busy, 0);
      in_valid = 0;
      cfg_valid = 1; cfg_screen_S = mk_scr(640, 480); cfg_subSample_U = 4'b0100;
      tick; #1;
      chk("post_rst_cfg_ready", cfg_ready, 1);
      cfg_valid = 0;
      tick; #1;
      chk("post_rst_screen", screen_RnnnnS, mk_scr(640, 480));
      chk("post_rst_in_ready", in_ready, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/rast_tri_sched.md
# rast_tri_sched

Triangle issue scheduler and configuration controller for the `rast` rasterizer.
- Buffers triangles from the upstream vertex stage in a small FIFO and issues them on the `rast` R10 input port, honouring `halt_RnnnnL` backpressure.
- Owns the `screen_RnnnnS` and `subSample_RnnnnU` configuration registers. Changes them only after the rasterizer pipeline has drained, so no in-flight triangle is ever sampled under mixed configuration.

## Interface
- SIGFIG, rast_params::SIGFIG, bits per coordinate/color
- VERTS, rast_params::VERTS, vertices per triangle
- AXIS, rast_params::AXIS, axes per vertex
- COLORS, rast_params::COLORS, color channels
- FIFO_DEPTH, 4, triangle buffer entries (power of 2, ≥2)
- DRAIN_CYCLES, 16, consecutive idle unhalted cycles that prove `rast` is empty (≥ rast pipeline depth)

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- in_tri_S  in  [VERTS][AXIS][SIGFIG] signed  upstream triangle
- in_color_U  in  [COLORS][SIGFIG]  upstream color
- in_valid  in  1  upstream triangle valid
- in_ready  out  1  triangle accepted when in_valid & in_ready
- cfg_screen_S  in  [2][SIGFIG] signed  requested screen dimensions
- cfg_subSample_U  in  4  requested subsample interval
- cfg_valid  in  1  config request; held with stable data until cfg_ready
- cfg_ready  out  1  one-cycle pulse: config applied
- tri_R10S  out  [VERTS][AXIS][SIGFIG] signed  to rast
- color_R10U  out  [COLORS][SIGFIG]  to rast
- validTri_R10H  out  1  to rast
- halt_RnnnnL  in  1  from rast; low = rast not accepting
- screen_RnnnnS  out  [2][SIGFIG] signed  to rast
- subSample_RnnnnU  out  4  to rast
- busy  out  1  FIFO non-empty or state ∈ {FLUSH, DRAIN, APPLY}
- tri_count  out  16  triangles issued since reset, wraps at 2^16

## Operation
- States: UNCFG, RUN, FLUSH, DRAIN, APPLY. Reset state: UNCFG.
- UNCFG: in_ready=0 and no issue. cfg_valid → APPLY.
- RUN:
  - in_ready = !full & !cfg_valid (config has priority over triangles in the same cycle).
  - cfg_valid → FLUSH.
- FLUSH:
  - in_ready=0; FIFO continues issuing.
  - FIFO count==0 at the start of the cycle → DRAIN, with the drain counter cleared.
- DRAIN:
  - in_ready=0, validTri_R10H=0.
  - Counter increments each cycle halt_RnnnnL=1 and clears on any cycle halt_RnnnnL=0.
  - Counter==DRAIN_CYCLES-1 with halt high → APPLY.
- APPLY:
  - cfg_ready=1 for this cycle only.
  - Screen/subsample registers load cfg_* at the end of the cycle.
  - Next state: RUN.
- Issue rules:
  - validTri_R10H = FIFO non-empty & state ∈ {RUN, FLUSH}.
  - tri_R10S/color_R10U = FIFO head.
  - Pop and tri_count increment occur iff validTri_R10H & halt_RnnnnL.
  - While halt_RnnnnL=0, the outputs hold stable.
- FIFO:
  - Push iff in_valid & in_ready.
  - Push and pop in the same cycle are both legal, including when the FIFO is full (in_ready still 0 when full; no pass-through).
  - Pointers wrap modulo FIFO_DEPTH.
- Reset values:
  - Outputs: in_ready=0, cfg_ready=0, validTri_R10H=0, busy=0, tri_count=0.
  - screen_RnnnnS={0,0}, subSample_RnnnnU=0.
  - tri_R10S/color_R10U=0.
- Reset mid-operation discards FIFO contents and any pending config; the block returns to UNCFG. Upstream must re-send config first.

## Timing
- Triangle pushed at cycle t into an empty FIFO, in RUN: validTri_R10H=1 at t+1. Popped at the first cycle ≥t+1 with halt_RnnnnL=1.
- Reconfig from RUN with an empty FIFO and halt high (cfg_valid at cycle 0):
  - FLUSH at cycle 1.
  - DRAIN over cycles 2..DRAIN_CYCLES+1.
  - APPLY / cfg_ready at cycle DRAIN_CYCLES+2.
  - New config visible at cycle DRAIN_CYCLES+3.
- UNCFG → APPLY takes one cycle; cfg_ready is asserted the cycle after cfg_valid is first seen.
- Sustained throughput: one triangle per cycle when halt_RnnnnL=1 and the FIFO is never empty.

## Structure
- Add to package rast_params:
  - tri_t (packed [VERTS][AXIS][SIGFIG] signed)
  - color_t
  - screen_t
  - sched_state_e (UNCFG, RUN, FLUSH, DRAIN, APPLY)
- Sub-module rast_tri_fifo: parameterized synchronous FIFO of {tri_t, color_t} with push/pop/full/empty/count.
- The FSM, drain counter, config registers and tri_count live in rast_tri_sched.

## Test plan
- Reset, then in_valid=1 with no config → in_ready=0 indefinitely. Send cfg {640,480,4'b0100} → cfg_ready at cycle+1; screen_RnnnnS={640,480} next cycle; in_ready=1 after.
- Stream 10 triangles with halt_RnnnnL=1 → 10 issues in order, back-to-back, tri_count=10.
- halt_RnnnnL=0 for 5 cycles mid-stream, FIFO_DEPTH=4 → in_ready drops after 4 pushes; tri_R10S stable while halted; no loss or duplication.
- cfg_valid and in_valid in the same RUN cycle with FIFO empty → triangle rejected; cfg_ready exactly 18 cycles later (DRAIN_CYCLES=16).
- Toggle halt_RnnnnL low at DRAIN count 10 → counter restarts; APPLY only after 16 consecutive high cycles.
- Assert rst with 3 triangles queued and cfg pending → next cycle: validTri_R10H=0, busy=0, tri_count=0, state UNCFG.
